// File: rtl/cond_exec_ctrl_pkg.sv
// Shared definitions for the ID-stage conditional-execution controller:
// condition-code encodings, status flag bit positions and FSM states.
package cond_exec_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Status register layout {C,N,V,Z}
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // AL and 1111 never consult the flags, so they can never hit a flag hazard
  function automatic logic cond_is_uncond(input logic [3:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/cond_exec_ctrl_if.sv
// ID-stage bundle between the pipeline and the conditional-execution controller.
interface cond_exec_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             freeze;
  logic             id_valid;
  logic [3:0]       id_cond;
  logic             id_s;
  logic             id_branch;
  logic [3:0]       exe_flags;
  logic [3:0]       status_q;
  logic             id_issue;
  logic             id_kill;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] kill_cnt;

  // Pipeline side: presents the ID instruction, consumes the decisions
  modport master (
    output freeze, id_valid, id_cond, id_s, id_branch, exe_flags,
    input  status_q, id_issue, id_kill, stall, flush, stall_cnt, kill_cnt
  );

  // Controller side
  modport slave (
    input  freeze, id_valid, id_cond, id_s, id_branch, exe_flags,
    output status_q, id_issue, id_kill, stall, flush, stall_cnt, kill_cnt
  );
endinterface

// File: rtl/cond_exec_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator: (cond, {C,N,V,Z}) -> pass.
module cond_eval
  import cond_exec_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic c, n, v, z;

  // Decode the condition field against the current flags
  always_comb begin
    c    = flags[FLAG_C];
    n    = flags[FLAG_N];
    v    = flags[FLAG_V];
    z    = flags[FLAG_Z];
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// ID-stage conditional-execution controller: owns the status flags, decides
// issue / kill / stall for each ID instruction, squashes the wrong path after
// a taken branch and keeps saturating stall/kill counters.
module cond_exec_ctrl
  import cond_exec_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,  // 1..3
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,                 // asynchronous, active-low
  cond_exec_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             exe_s_q, exe_s_d;
  logic [3:0]       status_q, status_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

  logic pass;
  logic run;
  logic hazard;
  logic issue;
  logic kill;

  cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .flags (status_q),
    .pass  (pass)
  );

  // Per-cycle issue/kill/stall decision; qualified by rst so nothing is
  // reported while the block is held in reset
  always_comb begin
    run    = (state_q == RUN);
    hazard = rst && run && bus.id_valid && exe_s_q && !cond_is_uncond(bus.id_cond);
    issue  = rst && run && bus.id_valid && pass  && !hazard && !bus.freeze;
    kill   = rst && run && bus.id_valid && !pass && !hazard && !bus.freeze;
  end

  // Next-state: flags, pending-S marker, squash FSM and counters; freeze holds all
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    exe_s_d     = exe_s_q;
    status_d    = status_q;
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (!bus.freeze) begin
      // A pending write always lands this edge; the marker then follows the
      // instruction issuing now, which covers both set and clear cases
      exe_s_d = issue && bus.id_s;
      if (exe_s_q) status_d = bus.exe_flags;
      if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (kill && (kill_cnt_q != '1))    kill_cnt_d  = kill_cnt_q + 1'b1;
      case (state_q)
        RUN: begin
          if (issue && bus.id_branch) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (fcnt_q == 2'd1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      exe_s_q     <= 1'b0;
      status_q    <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      exe_s_q     <= exe_s_d;
      status_q    <= status_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign bus.status_q  = status_q;
  assign bus.id_issue  = issue;
  assign bus.id_kill   = kill;
  assign bus.stall     = hazard;
  assign bus.flush     = (state_q == FLUSH);
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.kill_cnt  = kill_cnt_q;

endmodule
